// File: rtl/rgb_frame_streamer_if.sv
// Pixel-stream bus between a frame source (master) and rgb_frame_streamer (slave).
interface rgb_frame_streamer_if #(
    parameter int DEPTH = 8
);
    logic [DEPTH-1:0] in_r;
    logic [DEPTH-1:0] in_g;
    logic [DEPTH-1:0] in_b;
    logic             enable;
    logic             enable_process;
    logic [DEPTH-1:0] out_pixel;
    logic [8:0]       out_x;
    logic [8:0]       out_y;
    logic             load_done;
    logic             busy;
    logic             finish;

    modport master (
        output in_r, in_g, in_b, enable, enable_process,
        input  out_pixel, out_x, out_y, load_done, busy, finish
    );

    modport slave (
        input  in_r, in_g, in_b, enable, enable_process,
        output out_pixel, out_x, out_y, load_done, busy, finish
    );
endinterface

// File: rtl/rgb_frame_streamer.sv
// Stores one RGB frame, then plays it back in raster order as a single-channel stream.
// Optional macro LUMA_OUT_EN: output (R + 2G + B) >> 2 instead of the G channel.
module rgb_frame_streamer #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int DEPTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rgb_frame_streamer_if.slave  bus
);
    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [8:0]    LAST_X    = 9'(IMG_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_PROC, PLAYBACK, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    wcnt;
    logic [AW-1:0]    rcnt;
    logic             rd_last;
    logic             rd_valid;
    logic [8:0]       x_cnt;
    logic [8:0]       y_cnt;
    logic [DEPTH-1:0] mem_r [N];
    logic [DEPTH-1:0] mem_g [N];
    logic [DEPTH-1:0] mem_b [N];
    logic [DEPTH-1:0] r_q;
    logic [DEPTH-1:0] g_q;
    logic [DEPTH-1:0] b_q;
    logic             wr_en;
    logic             rd_en;
    logic [AW-1:0]    wr_addr;
    logic [DEPTH-1:0] pix_next;

    assign wr_en   = bus.enable && (state == IDLE || state == LOAD);
    assign wr_addr = (state == IDLE) ? '0 : wcnt;
    assign rd_en   = (state == PLAYBACK) && !rd_last;

    // Frame memory is never reset; only the control path is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= bus.in_r;
            mem_g[wr_addr] <= bus.in_g;
            mem_b[wr_addr] <= bus.in_b;
        end
        if (rd_en) begin
            r_q <= mem_r[rcnt];
            g_q <= mem_g[rcnt];
            b_q <= mem_b[rcnt];
        end
    end

`ifdef LUMA_OUT_EN
    logic [DEPTH+1:0] luma_sum;
    assign luma_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, b_q};
    assign pix_next = luma_sum[DEPTH+1:2];
`else
    logic unused_rb;
    assign unused_rb = ^{r_q, b_q};
    assign pix_next  = g_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wcnt          <= '0;
            rcnt          <= '0;
            rd_last       <= 1'b0;
            rd_valid      <= 1'b0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            bus.out_pixel <= '0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.load_done <= 1'b0;
            bus.busy      <= 1'b0;
            bus.finish    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        wcnt <= AW'(1);
                        if (LAST_ADDR == '0) begin
                            state         <= WAIT_PROC;
                            bus.load_done <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.enable) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_ADDR) begin
                            state         <= WAIT_PROC;
                            bus.busy      <= 1'b0;
                            bus.load_done <= 1'b1;
                        end
                    end
                end
                WAIT_PROC: begin
                    if (bus.enable_process) begin
                        state         <= PLAYBACK;
                        bus.busy      <= 1'b1;
                        bus.load_done <= 1'b0;
                        rcnt          <= '0;
                        rd_last       <= 1'b0;
                        rd_valid      <= 1'b0;
                        x_cnt         <= '0;
                        y_cnt         <= '0;
                    end
                end
                PLAYBACK: begin
                    // Two-stage pipe: address issue, then registered read data to outputs.
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == LAST_ADDR) rd_last <= 1'b1;
                    end
                    if (rd_valid) begin
                        bus.out_pixel <= pix_next;
                        bus.out_x     <= x_cnt;
                        bus.out_y     <= y_cnt;
                        bus.finish    <= 1'b1;
                        if (x_cnt == LAST_X) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end else begin
                        bus.finish <= 1'b0;
                        if (rd_last) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!bus.enable_process) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_frame_streamer.sv
// Self-checking bench for rgb_frame_streamer on a 4x2 frame, scoreboard driven.
module tb_rgb_frame_streamer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 8;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] pix;
        logic [8:0] x;
        logic [8:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] r_tab [N];
    logic [7:0] g_tab [N];
    logic [7:0] b_tab [N];

    always #5 clk = ~clk;

    rgb_frame_streamer_if #(.DEPTH(D)) bus ();

    rgb_frame_streamer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DEPTH     (D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] model(input int i);
`ifdef LUMA_OUT_EN
        return 8'((int'(r_tab[i]) + 2 * int'(g_tab[i]) + int'(b_tab[i])) >> 2);
`else
        return g_tab[i];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every valid output cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && bus.finish) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_finish", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("out_pixel", bus.out_pixel, mon_e.pix);
                checkOutput("out_x", bus.out_x, mon_e.x);
                checkOutput("out_y", bus.out_y, mon_e.y);
            end
        end
    end

    task automatic fillTables(input int seed);
        for (int i = 0; i < N; i++) begin
            r_tab[i] = 8'(i * 3 + seed);
            g_tab[i] = 8'(i * 10 + seed);
            b_tab[i] = 8'(i * 5 + 2 * seed);
        end
    endtask

    task automatic applyStimulus(input bit gap, input bit ep_during);
        for (int i = 0; i < N; i++) begin
            bus.enable         = 1'b1;
            bus.in_r           = r_tab[i];
            bus.in_g           = g_tab[i];
            bus.in_b           = b_tab[i];
            bus.enable_process = ep_during;
            exp_q.push_back('{pix: model(i), x: 9'(i % W), y: 9'(i / W)});
            tick();
            checkOutput("load_done", bus.load_done, 32'(i == N - 1));
            checkOutput("busy_load", bus.busy, 32'(i != N - 1));
            if (gap && i != N - 1) begin
                bus.enable = 1'b0;
                bus.in_r   = 8'hEE;
                bus.in_g   = 8'hEE;
                bus.in_b   = 8'hEE;
                tick();
                checkOutput("load_done_gap", bus.load_done, 32'd0);
            end
        end
        bus.enable         = 1'b0;
        bus.enable_process = 1'b0;
    endtask

    task automatic playFrame(input bit hold_ep, input int abort_at);
        int         count;
        int         guard;
        logic [7:0] last_pix;
        last_pix = model(N - 1);
        bus.enable_process = 1'b1;
        tick();
        if (!hold_ep) bus.enable_process = 1'b0;
        checkOutput("busy_play", bus.busy, 32'd1);
        checkOutput("load_done_clr", bus.load_done, 32'd0);
        checkOutput("finish_e0", bus.finish, 32'd0);
        tick();
        checkOutput("finish_e1", bus.finish, 32'd0);
        tick();
        checkOutput("finish_first", bus.finish, 32'd1);
        count = 1;
        guard = 0;
        while (bus.finish && guard < N + 8) begin
            if (abort_at > 0 && count == abort_at + 1) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_finish", bus.finish, 32'd0);
                checkOutput("rst_busy", bus.busy, 32'd0);
                checkOutput("rst_load_done", bus.load_done, 32'd0);
                checkOutput("rst_out_pixel", bus.out_pixel, 32'd0);
                checkOutput("rst_out_x", bus.out_x, 32'd0);
                checkOutput("rst_out_y", bus.out_y, 32'd0);
                exp_q.delete();
                tick();
                rst_n = 1'b1;
                return;
            end
            tick();
            guard++;
            if (bus.finish) count++;
        end
        checkOutput("finish_len", count, N);
        checkOutput("busy_done", bus.busy, 32'd0);
        checkOutput("out_x_hold", bus.out_x, W - 1);
        checkOutput("out_y_hold", bus.out_y, H - 1);
        checkOutput("out_pixel_hold", bus.out_pixel, last_pix);
        checkOutput("queue_empty", exp_q.size(), 32'd0);
        if (!hold_ep) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_r           = '0;
        bus.in_g           = '0;
        bus.in_b           = '0;
        bus.enable         = 1'b0;
        bus.enable_process = 1'b0;
        #12;
        checkOutput("reset_finish", bus.finish, 32'd0);
        checkOutput("reset_busy", bus.busy, 32'd0);
        checkOutput("reset_load_done", bus.load_done, 32'd0);
        checkOutput("reset_out_pixel", bus.out_pixel, 32'd0);
        checkOutput("reset_out_x", bus.out_x, 32'd0);
        checkOutput("reset_out_y", bus.out_y, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic load and playback");
        for (int i = 0; i < N; i++) begin
            r_tab[i] = 8'(i * 3 + 1);
            g_tab[i] = 8'(i * 10);
            b_tab[i] = 8'(i * 5 + 2);
        end
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("wait_load_done", bus.load_done, 32'd1);
        playFrame(1'b0, 0);

        $display("[TB] luma corner pixels, enable ignored while waiting");
        for (int i = 0; i < N; i++) begin
            r_tab[i] = 8'($urandom);
            g_tab[i] = 8'($urandom);
            b_tab[i] = 8'($urandom);
        end
        r_tab[0] = 8'd255; g_tab[0] = 8'd255; b_tab[0] = 8'd255;
        r_tab[1] = 8'd4;   g_tab[1] = 8'd8;   b_tab[1] = 8'd12;
        applyStimulus(1'b0, 1'b0);
        bus.enable = 1'b1;
        bus.in_r   = 8'h33;
        bus.in_g   = 8'h33;
        bus.in_b   = 8'h33;
        tick();
        tick();
        bus.enable = 1'b0;
        checkOutput("wait_ignores_enable", bus.load_done, 32'd1);
        playFrame(1'b0, 0);

        $display("[TB] load with enable toggling");
        fillTables(7);
        applyStimulus(1'b1, 1'b0);
        playFrame(1'b0, 0);

        $display("[TB] enable_process during load is not remembered");
        fillTables(21);
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("no_early_finish", bus.finish, 32'd0);
            checkOutput("no_early_busy", bus.busy, 32'd0);
        end
        playFrame(1'b0, 0);

        $display("[TB] reset during playback");
        fillTables(40);
        applyStimulus(1'b0, 1'b0);
        playFrame(1'b0, 3);
        fillTables(55);
        applyStimulus(1'b0, 1'b0);
        playFrame(1'b0, 0);

        $display("[TB] enable_process held after playback");
        fillTables(90);
        applyStimulus(1'b0, 1'b0);
        playFrame(1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("done_no_replay", bus.finish, 32'd0);
            checkOutput("done_busy", bus.busy, 32'd0);
        end
        bus.enable_process = 1'b0;
        tick();
        fillTables(123);
        applyStimulus(1'b0, 1'b0);
        playFrame(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rgb_frame_streamer.md
Name: rgb_frame_streamer

Overview:
- Synthesizable receiving end of the face-detection pixel-stream interface.
- Accepts one RGB pixel per clock into an internal frame buffer during the load phase.
- On a process request, plays the frame back in raster order as a single-channel stream with pixel coordinates.
- The output stream uses the same "finish high = output valid" convention the downstream mask/centroid writers use.

Parameters:
IMG_WIDTH, 256, pixels per row
IMG_HEIGHT, 256, rows per frame
DEPTH, 8, bits per colour channel and per output pixel

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_r  in  DEPTH  red channel of incoming pixel
in_g  in  DEPTH  green channel of incoming pixel
in_b  in  DEPTH  blue channel of incoming pixel
enable  in  1  load strobe; pixel on in_r/g/b is valid this cycle
enable_process  in  1  request playback of the stored frame
out_pixel  out  DEPTH  playback pixel value
out_x  out  9  column of out_pixel
out_y  out  9  row of out_pixel
load_done  out  1  full frame stored, waiting for enable_process
busy  out  1  high in LOAD or PLAYBACK
finish  out  1  out_pixel/out_x/out_y valid this cycle

Behaviour:
- Reset, asynchronous, active-low, legal at any time including mid-load or mid-playback:
  - state = IDLE; write counter, read counter, and x/y counters = 0.
  - All outputs = 0.
  - Frame memory contents are not cleared.
- N = IMG_WIDTH*IMG_HEIGHT. Memories: three arrays of N x DEPTH (R, G, B), synchronous write, registered read.
- IDLE:
  - enable=1: write pixel to address 0, wcnt=1, go to LOAD.
  - enable_process ignored. If enable and enable_process are both 1, load wins.
- LOAD:
  - Each cycle with enable=1: write to address wcnt, then wcnt++.
  - enable=0: stall. No write, no state change.
  - The write of address N-1 moves to WAIT_PROC on the next edge. Pixels beyond N are never written.
  - enable_process ignored and not remembered.
- WAIT_PROC:
  - load_done=1; enable ignored.
  - enable_process=1 (sampled on edge E): go to PLAYBACK and clear load_done.
- PLAYBACK:
  - Read address 0 is issued at edge E+1. finish rises at edge E+2 with the pixel at address 0.
  - finish then stays high exactly N consecutive cycles, one pixel per cycle in raster order, no gaps.
  - enable_process may drop during playback without effect.
- out_x/out_y:
  - Registered alongside out_pixel.
  - out_x increments each valid cycle and wraps from IMG_WIDTH-1 to 0; out_y increments on the wrap.
  - Last pixel: (IMG_WIDTH-1, IMG_HEIGHT-1).
- DONE:
  - Entered on the cycle after the last valid pixel. finish=0, busy=0.
  - Outputs hold their last values.
  - enable_process=0: go to IDLE. enable_process=1: stay in DONE, no replay.
  - A new frame can be loaded only from IDLE.
- busy: high in LOAD and PLAYBACK, low otherwise.
- Arithmetic:
  - Counters are $clog2(N) bits, minimum 1.
  - Luma sum (see Optional Feature) is DEPTH+2 bits wide, so there is no overflow.

Optional Feature:
- Macro: LUMA_OUT_EN.
- Defined: out_pixel = (R + 2*G + B) >> 2, computed from the registered read data in the same output cycle. Latency is unchanged.
- Undefined: out_pixel = G channel only. R and B memories are still written, so load timing is identical.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, no macro. Load pixels i=0..7 with G=i*10, enable held high 8 cycles, then pulse enable_process → load_done high in WAIT_PROC; finish high exactly 8 cycles starting 2 edges after the pulse; out_pixel 0,10,…,70; (x,y) sequence (0,0)…(3,0),(0,1)…(3,1).
- LUMA_OUT_EN, pixel 0 with R=255, G=255, B=255; pixel 1 with R=4, G=8, B=12 → out_pixel 255 then 8.
- Load with enable toggling 1,0,1,0 → only enable=1 cycles are written; load_done after the 8th written pixel, not the 8th clock; playback order unchanged.
- enable_process asserted during LOAD, then held low → no playback; after load completes, finish stays 0 until a fresh enable_process.
- Drive rst_n low for 1 cycle at playback pixel 3 → finish, busy, load_done, out_* all 0 immediately; state IDLE; a new 8-pixel load and playback then complete correctly.
- Hold enable_process high after playback → DONE with finish=0 and no replay; release → IDLE; enable=1 then starts a new load at address 0.
